// File: rtl/systolic_ctrl.sv
// Sequencer for a weight-stationary ARRAY_DIM x ARRAY_DIM systolic array:
// optional weight-load pass, then skewed operand feed and result-valid strobes.
module systolic_ctrl #(
  parameter int ARRAY_DIM = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 load_w_i,
  input  logic [CNT_W-1:0]     vec_count_i,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 w_feed_o,
  output logic [ARRAY_DIM-1:0] weight_we_o,
  output logic                 mux_ctrl_o,
  output logic [ARRAY_DIM-1:0] row_feed_en_o,
  output logic [ARRAY_DIM-1:0] col_out_valid_o
);

  // Wide enough for M + 2*ARRAY_DIM - 2 at M = 2^CNT_W-1 without wrap.
  localparam int TW = CNT_W + $clog2(2 * ARRAY_DIM);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] m_q, m_d;
  logic [TW-1:0]    m_ext;
  logic             streaming;

  assign m_ext = TW'(m_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          m_d = vec_count_i;
          if (load_w_i)                state_d = S_LOAD;
          else if (vec_count_i == '0)  state_d = S_DONE;
          else                         state_d = S_COMPUTE;
        end
      end
      S_LOAD: begin
        if (cnt_q == TW'(ARRAY_DIM - 1)) begin
          cnt_d   = '0;
          state_d = (m_q == '0) ? S_DONE : S_COMPUTE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_COMPUTE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q + 1'b1 == m_ext) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_q == m_ext + TW'(2 * ARRAY_DIM - 2)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are pure decodes of the state/counter flops, so reset clears them at once.
  assign streaming = (state_q == S_COMPUTE) || (state_q == S_DRAIN);

  always_comb begin
    ready_o         = (state_q == S_IDLE);
    busy_o          = (state_q == S_LOAD) || streaming;
    done_o          = (state_q == S_DONE);
    w_feed_o        = (state_q == S_LOAD);
    mux_ctrl_o      = (state_q == S_LOAD);
    weight_we_o     = '0;
    row_feed_en_o   = '0;
    col_out_valid_o = '0;
    if ((state_q == S_LOAD) && (cnt_q == TW'(ARRAY_DIM - 1))) weight_we_o = '1;
    for (int r = 0; r < ARRAY_DIM; r++) begin
      row_feed_en_o[r]   = streaming && (cnt_q >= TW'(r)) &&
                           (cnt_q < TW'(r) + m_ext);
      col_out_valid_o[r] = streaming && (cnt_q >= TW'(r + ARRAY_DIM)) &&
                           (cnt_q < TW'(r + ARRAY_DIM) + m_ext);
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: a run-level model queues the expected
// per-cycle output vector; a negedge monitor pops and compares.
module tb_systolic_ctrl;
  localparam int D  = 4;
  localparam int CW = 8;
  localparam int VW = 5 + 3 * D;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          load_w = 1'b0;
  logic [CW-1:0] vec_count = '0;
  logic          ready, busy, done, w_feed, mux_ctrl;
  logic [D-1:0]  weight_we, row_feed_en, col_out_valid;

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] exp_q[$];

  systolic_ctrl #(.ARRAY_DIM(D), .CNT_W(CW)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .load_w_i(load_w),
    .vec_count_i(vec_count), .ready_o(ready), .busy_o(busy), .done_o(done),
    .w_feed_o(w_feed), .weight_we_o(weight_we), .mux_ctrl_o(mux_ctrl),
    .row_feed_en_o(row_feed_en), .col_out_valid_o(col_out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] mk(bit rdy, bit bsy, bit dn, bit wf, bit mx,
                                        logic [D-1:0] we, logic [D-1:0] row,
                                        logic [D-1:0] col);
    return {rdy, bsy, dn, wf, mx, we, row, col};
  endfunction

  function automatic logic [VW-1:0] actual();
    return {ready, busy, done, w_feed, mux_ctrl, weight_we, row_feed_en, col_out_valid};
  endfunction

  task automatic check(string name, logic [VW-1:0] act, logic [VW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Expected cycle-by-cycle response of one accepted request.
  task automatic push_run(bit ld, int m);
    logic [D-1:0] row, col;
    if (ld)
      for (int k = 0; k < D; k++)
        exp_q.push_back(mk(0, 1, 0, 1, 1, (k == D-1) ? {D{1'b1}} : {D{1'b0}}, '0, '0));
    if (m > 0)
      for (int t = 0; t <= m + 2*D - 2; t++) begin
        for (int i = 0; i < D; i++) begin
          row[i] = (t >= i) && (t <= i + m - 1);
          col[i] = (t >= i + D) && (t <= i + D + m - 1);
        end
        exp_q.push_back(mk(0, 1, 0, 0, 0, '0, row, col));
      end
    exp_q.push_back(mk(0, 0, 1, 0, 0, '0, '0, '0));
  endtask

  initial begin : monitor
    logic [VW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy || done) begin
          if (exp_q.size() == 0) check("unexpected_activity", actual(), mk(1, 0, 0, 0, 0, '0, '0, '0));
          else begin
            e = exp_q.pop_front();
            check("run_cycle", actual(), e);
          end
        end else begin
          check("idle", actual(), mk(1, 0, 0, 0, 0, '0, '0, '0));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(bit ld, int m, bit spam);
    int guard;
    tick();
    start = 1'b1; load_w = ld; vec_count = m[CW-1:0];
    push_run(ld, m);
    tick();
    start = 1'b0; load_w = 1'($urandom); vec_count = CW'($urandom);
    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      if (spam) begin
        start = 1'($urandom_range(0, 1)); vec_count = 8'd9; load_w = 1'($urandom);
      end
      tick();
      guard++;
    end
    start = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL run_timeout: %0d expected cycles never presented (ld=%0d m=%0d)",
               exp_q.size(), ld, m);
      exp_q.delete();
    end
    repeat (2) tick();
  endtask

  initial begin
    #2;
    check("reset_state", actual(), mk(1, 0, 0, 0, 0, '0, '0, '0));
    #20 rst = 1'b0;

    run(1, 3, 0);
    run(0, 1, 0);
    run(1, 0, 0);
    run(0, 0, 0);
    run(1, 3, 1);

    // Reset asserted between edges at t=2 of COMPUTE.
    tick();
    start = 1'b1; load_w = 1'b0; vec_count = 8'd5; push_run(0, 5);
    tick(); start = 1'b0;
    tick();
    tick();
    #1 rst = 1'b1;
    #1 check("async_reset_mid_run", actual(), mk(1, 0, 0, 0, 0, '0, '0, '0));
    exp_q.delete();
    #1 rst = 1'b0;
    run(1, 2, 0);

    for (int i = 0; i < 25; i++)
      run(1'($urandom_range(0, 1)), $urandom_range(0, 10), 1'($urandom_range(0, 1)));
    run(0, 255, 1);
    run(1, 255, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
